// File: rtl/sync_filter_pkg.sv
// rtl/sync_filter_pkg.sv - shared constants and helpers for the sync_filter_reg bank
package sync_filter_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 4;

  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// rtl/sync_filter_bit.sv - one bit: sync chain, glitch-filter counter, Q and edge pulses
// Edge registers exist only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_bit
  import sync_filter_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_sload,
  input  logic i_sval,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_stable
);

  localparam int            CW   = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic [SYNC_STAGES:0]   w_chain;
  logic                   w_sl;
  logic                   w_diff;
  logic                   w_accept;

  assign w_chain  = {r_sync, i_d};
  assign w_sl     = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_sl ^ r_q;
  assign w_accept = w_diff && (r_cnt == TERM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_cnt  <= '0;
      r_q    <= RESET_VAL;
    end else if (i_sload) begin
      r_sync <= {SYNC_STAGES{i_sval}};
      r_cnt  <= '0;
      r_q    <= i_sval;
    end else begin
      r_sync <= w_chain[SYNC_STAGES-1:0];
      // Any agreement with Q before terminal count throws away the partial run.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_q   <= w_sl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_sload) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept && w_sl;
      r_fall <= w_accept && !w_sl;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

  assign o_q      = r_q;
  assign o_stable = (r_cnt == '0) && (r_sync == {SYNC_STAGES{r_q}});

endmodule

// File: rtl/sync_filter_reg.sv
// rtl/sync_filter_reg.sv - WIDTH-bit synchronising glitch filter with per-bit edge pulses
// RISE/FALL are live only when SYNC_FILTER_EDGE_EN is defined; otherwise tied to 0.
module sync_filter_reg
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int               FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             SLOAD,
  input  logic [WIDTH-1:0] SVAL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             STABLE
);

  logic [WIDTH-1:0] w_stable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_filter_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[i])
    ) u_bit (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_d     (D[i]),
      .i_sload (SLOAD),
      .i_sval  (SVAL[i]),
      .o_q     (Q[i]),
      .o_rise  (RISE[i]),
      .o_fall  (FALL[i]),
      .o_stable(w_stable[i])
    );
  end

  assign STABLE = &w_stable;

endmodule

// File: tb/tb_sync_filter_reg.sv
// tb/tb_sync_filter_reg.sv - self-checking bench for sync_filter_reg
module tb_sync_filter_reg;

  localparam int         W  = 4;
  localparam int         SS = 2;
  localparam int         FC = 4;
  localparam logic [3:0] RV = 4'b1010;
`ifdef SYNC_FILTER_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SLOAD;
  logic [3:0] D, SVAL, Q, RISE, FALL;
  logic       STABLE;

  always #5 CLK = ~CLK;

  sync_filter_reg #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .RESET_VAL(RV)) dut (
    .CLK(CLK), .RESET(RESET), .D(D), .SLOAD(SLOAD), .SVAL(SVAL),
    .Q(Q), .RISE(RISE), .FALL(FALL), .STABLE(STABLE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: sampled levels travel through an SS-deep delay line; a bit of Q
  // follows the delayed level once it has disagreed with Q for FC edges in a row.
  logic [3:0] m_line[$];
  logic [3:0] m_q, m_rise, m_fall;
  int         m_run[4];

  task automatic m_set(input logic [3:0] v);
    m_line = {};
    repeat (SS) m_line.push_back(v);
    m_q = v; m_rise = '0; m_fall = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
  endtask

  task automatic m_edge();
    logic [3:0] sl;
    if (SLOAD) begin
      m_set(SVAL);
    end else begin
      sl = m_line[$];
      m_rise = '0; m_fall = '0;
      for (int b = 0; b < 4; b++) begin
        if (sl[b] != m_q[b]) begin
          m_run[b]++;
          if (m_run[b] == FC) begin
            if (EDGE_ON) begin
              if (sl[b]) m_rise[b] = 1'b1;
              else       m_fall[b] = 1'b1;
            end
            m_q[b] = sl[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_line.push_front(D);
      void'(m_line.pop_back());
    end
  endtask

  function automatic logic m_stable();
    logic s;
    s = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (m_run[b] != 0) s = 1'b0;
      foreach (m_line[k]) if (m_line[k][b] != m_q[b]) s = 1'b0;
    end
    return s;
  endfunction

  task automatic step(input string tag);
    @(posedge CLK);
    m_edge();
    #1;
    chk({tag, ".q"},      Q,      m_q);
    chk({tag, ".rise"},   RISE,   m_rise);
    chk({tag, ".fall"},   FALL,   m_fall);
    chk({tag, ".stable"}, STABLE, m_stable());
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic       stable;
  } vec_t;

  vec_t tbl[8];
  int   glitch_bad, rise_cyc, fall_cyc, rise_cnt, fall_cnt;
  logic [3:0] q_prev;

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].d      = 4'b1011;
      tbl[i].q      = (i >= 5) ? 4'b1011 : 4'b1010;
      tbl[i].rise   = (i == 5 && EDGE_ON) ? 4'b0001 : 4'b0000;
      tbl[i].stable = (i >= 5);
    end

    RESET = 1'b0; SLOAD = 1'b0; SVAL = '0; D = RV;
    m_set(RV);
    #12;
    chk("rst.q", Q, RV);
    chk("rst.rise", RISE, 4'b0);
    chk("rst.fall", FALL, 4'b0);
    chk("rst.stable", STABLE, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) step("idle");

    // Latency: bit 0 rises before edge 0 and is held
    for (int i = 0; i < 8; i++) begin
      D = tbl[i].d;
      step("lat_m");
      chk($sformatf("lat%0d.q", i), Q, tbl[i].q);
      chk($sformatf("lat%0d.rise", i), RISE, tbl[i].rise);
      chk($sformatf("lat%0d.fall", i), FALL, 4'b0);
      chk($sformatf("lat%0d.stable", i), STABLE, tbl[i].stable);
    end

    // Load wins over a change pending on bit 2
    D = 4'b1111;
    repeat (3) step("ld_pre");
    SLOAD = 1'b1; SVAL = 4'b0101; D = 4'b0101;
    step("ld");
    chk("ld.q", Q, 4'b0101);
    chk("ld.edges", RISE | FALL, 4'b0);
    chk("ld.stable", STABLE, 1'b1);
    SLOAD = 1'b0;
    repeat (2) step("ld_post");

    // Three-cycle glitch on bit 1 is rejected
    glitch_bad = 0;
    D = 4'b0111;
    repeat (3) begin
      step("gl");
      if (Q[1] || RISE[1] || FALL[1]) glitch_bad++;
    end
    D = 4'b0101;
    repeat (8) begin
      step("gl");
      if (Q[1] || RISE[1] || FALL[1]) glitch_bad++;
    end
    chk("glitch.disturb", glitch_bad, 0);
    chk("glitch.stable", STABLE, 1'b1);

    // Exactly four cycles is accepted; release follows four cycles later
    rise_cyc = -1; fall_cyc = -1; rise_cnt = 0; fall_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      D = (c < 4) ? 4'b0111 : 4'b0101;
      q_prev = Q;
      step("bnd");
      if (!q_prev[1] && Q[1]) rise_cyc = c;
      if (q_prev[1] && !Q[1]) fall_cyc = c;
      if (RISE[1]) rise_cnt++;
      if (FALL[1]) fall_cnt++;
    end
    chk("bnd.rise_cyc", rise_cyc, 5);
    chk("bnd.fall_gap", fall_cyc - rise_cyc, 4);
    chk("bnd.rise_pulses", rise_cnt, int'(EDGE_ON));
    chk("bnd.fall_pulses", fall_cnt, int'(EDGE_ON));

    // Random traffic against the reference
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) D[b] = ~D[b];
      SLOAD = ($urandom_range(0, 24) == 0);
      SVAL  = 4'($urandom);
      step("rnd");
    end
    SLOAD = 1'b0;

    // Asynchronous reset in the middle of a cycle
    D = 4'b0101;
    @(posedge CLK);
    m_edge();
    #3;
    RESET = 1'b0;
    #1;
    chk("arst.q", Q, RV);
    chk("arst.rise", RISE, 4'b0);
    chk("arst.fall", FALL, 4'b0);
    chk("arst.stable", STABLE, 1'b1);
    m_set(RV);
    D = RV;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (4) step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_filter_reg.md
# sync_filter_reg

Parametrised successor to the single-bit D register: a WIDTH-bit bank that synchronises asynchronous inputs into the CLK domain, rejects glitches shorter than a programmable number of cycles, and reports per-bit rising and falling edges. It sits at every asynchronous input boundary of the synced-clock top level, feeding control FSMs that require clean, single-cycle edge events.

## Interface
- WIDTH, 1: number of independent bits (≥1).
- SYNC_STAGES, 2: synchroniser flops per bit (≥1).
- FILTER_CYCLES, 4: consecutive cycles a new level must persist before Q accepts it (≥1; 1 means no filtering).
- RESET_VAL, {WIDTH{1'b0}}: value of sync chain and Q after reset.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- D  in  WIDTH  asynchronous input bits.
- SLOAD  in  1  synchronous load strobe.
- SVAL  in  WIDTH  value forced by SLOAD.
- Q  out  WIDTH  filtered, synchronised level.
- RISE  out  WIDTH  one-cycle pulse per bit on a Q 0→1 transition.
- FALL  out  WIDTH  one-cycle pulse per bit on a Q 1→0 transition.
- STABLE  out  1  high when no bit has a pending change.

## Operation
- Per bit: sync chain s[0..SYNC_STAGES-1], with s[0] capturing D; filter counter cnt; output register Q.
- Priority: RESET > SLOAD > normal filtering.
- RESET low (asynchronous): all sync stages and Q = RESET_VAL, cnt = 0, RISE = FALL = 0. STABLE reads 1.
- SLOAD high at an edge: all sync stages and Q = SVAL, cnt = 0, RISE = FALL = 0. No edge pulses are generated by a load.
- Normal operation, per bit, with sl = last sync stage:
  - sl == Q: cnt ← 0.
  - sl != Q and cnt < FILTER_CYCLES-1: cnt ← cnt+1.
  - sl != Q and cnt == FILTER_CYCLES-1: Q ← sl, cnt ← 0, and RISE or FALL ← 1 for that bit.
  - In every other case, RISE and FALL ← 0.
- Any cycle in which sl equals Q before the terminal count clears cnt. A glitch therefore never partially carries over to a later change.
- Bits are fully independent. Simultaneous changes on several bits each follow their own counter.
- STABLE is combinational from registers: high when, for every bit, cnt == 0 and every sync stage equals Q.
- Counter width: max(1, $clog2(FILTER_CYCLES)). The counter never wraps, because it is cleared at the terminal count.

## Timing
- Take D stable from before edge k onward, with the new value differing from Q.
- s[0] captures the value at edge k. sl holds it after edge k+SYNC_STAGES-1.
- Q, and the matching RISE/FALL, update at edge k+SYNC_STAGES+FILTER_CYCLES-1.
- RISE/FALL are registered, coincide with the Q update, and are high for exactly one cycle.
- A D pulse is rejected if, after synchronisation, it lasts fewer than FILTER_CYCLES cycles: Q, RISE and FALL stay unchanged.
- A pulse of exactly FILTER_CYCLES cycles is accepted.
- SLOAD takes effect at the edge where it is sampled high. Filtering of D resumes at the next edge.
- RESET is asserted asynchronously and must be deasserted synchronously to CLK; upstream logic guarantees this.
- Mid-filter reset or load discards the pending change.

## Configuration
- SYNC_FILTER_EDGE_EN defined: RISE and FALL are generated as described.
- SYNC_FILTER_EDGE_EN undefined:
  - RISE and FALL are tied to 0.
  - Their registers are not built.
  - Q, STABLE and latency are unchanged.

## Structure
- Package sync_filter_pkg holds:
  - function cnt_width(FILTER_CYCLES), returning max(1, $clog2(FILTER_CYCLES));
  - the default constants for SYNC_STAGES and FILTER_CYCLES.
- Sub-module sync_filter_bit implements one bit: sync chain, counter, Q, and edge registers.
- The top level generates WIDTH instances and AND-reduces the per-bit stable flags into STABLE.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b1010, RESET low mid-cycle -> Q=4'b1010 immediately, RISE=FALL=0, STABLE=1.
- Latency: SYNC_STAGES=2, FILTER_CYCLES=4, D[0] 0→1 before edge 0 and held -> Q[0]=1 and RISE[0]=1 after edge 5, RISE[0]=0 after edge 6.
- Glitch reject: D[1] high for 3 cycles (FILTER_CYCLES=4) -> Q[1], RISE[1] and FALL[1] never change. STABLE returns to 1 once sync stages and Q[1] agree again.
- Boundary: D[1] high for exactly 4 cycles -> RISE[1] pulse, then FALL[1] pulse 4 cycles later.
- Load priority: SLOAD=1 with SVAL=4'b0101 while D[2] is mid-filter -> Q=4'b0101 next edge, no RISE/FALL, cnt cleared.
- Macro off: same stimulus as the latency test without SYNC_FILTER_EDGE_EN -> Q timing identical, RISE=FALL=0 throughout.
